serial_compare_ctrl: RTL

Sequencing controller for the bit-serial unsigned comparator. It accepts two WIDTH-bit operands on a start pulse and loads them into two MSB-first shift stages. It clocks them for WIDTH cycles, folds the serial bit pairs into a sticky gt/lt decision, and reports the registered result with a one-cycle done pulse. It sits between the issuing logic and the serial shift datapath and owns load/shift timing.

---
 rtl/serial_cmp_pkg.sv | 18 +
 rtl/serial_msb_shifter.sv | 34 +++
 rtl/serial_compare_ctrl.sv | 112 +++++++++++
 3 files changed

// File: rtl/serial_cmp_pkg.sv
// Shared types and constants for the bit-serial unsigned comparator controller.
package serial_cmp_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StCmp  = 2'd1,
        StDone = 2'd2
    } cmp_state_t;

    localparam int unsigned DEFAULT_WIDTH = 32;

    // Result vector ordering is {gt, eq, lt}.
    localparam logic [2:0] RES_NONE = 3'b000;
    localparam logic [2:0] RES_GT   = 3'b100;
    localparam logic [2:0] RES_EQ   = 3'b010;
    localparam logic [2:0] RES_LT   = 3'b001;

endpackage

// File: rtl/serial_msb_shifter.sv
// WIDTH-bit load/shift register, MSB-first, zero-filled; load takes priority over shift.
module serial_msb_shifter #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_i,
    input  logic             shift_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             msb_o
);

    logic [WIDTH-1:0] sr_q, sr_d;

    always_comb begin
        sr_d = sr_q;
        if (load_i) begin
            sr_d = data_i;
        end else if (shift_i) begin
            sr_d = {sr_q[WIDTH-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_d;
        end
    end

    assign msb_o = sr_q[WIDTH-1];

endmodule

// File: rtl/serial_compare_ctrl.sv
// Sequencing controller for the bit-serial unsigned comparator.
// Optional: define EARLY_EXIT_EN to finish on the first differing bit.
module serial_compare_ctrl
    import serial_cmp_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             gt_o,
    output logic             eq_o,
    output logic             lt_o
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    cmp_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             decided_q, decided_d;
    logic             dir_q, dir_d;
    logic [2:0]       res_q, res_d;
    logic             load, shift, finish;
    logic             a_msb, b_msb;

    serial_msb_shifter #(.WIDTH(WIDTH)) u_shift_a (
        .clk     (clk),
        .reset   (reset),
        .load_i  (load),
        .shift_i (shift),
        .data_i  (a_i),
        .msb_o   (a_msb)
    );

    serial_msb_shifter #(.WIDTH(WIDTH)) u_shift_b (
        .clk     (clk),
        .reset   (reset),
        .load_i  (load),
        .shift_i (shift),
        .data_i  (b_i),
        .msb_o   (b_msb)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        decided_d = decided_q;
        dir_d     = dir_q;
        res_d     = res_q;
        load      = 1'b0;
        shift     = 1'b0;
        finish    = 1'b0;
        case (state_q)
            StIdle, StDone: begin
                if (start_i) begin
                    load      = 1'b1;
                    cnt_d     = CNT_W'(WIDTH);
                    decided_d = 1'b0;
                    dir_d     = 1'b0;
                    res_d     = RES_NONE;
                    state_d   = StCmp;
                end else begin
                    state_d   = StIdle;
                end
            end
            StCmp: begin
                shift = 1'b1;
                cnt_d = cnt_q - 1'b1;
                // Sticky: only the first differing bit pair sets the direction.
                if (!decided_q && (a_msb != b_msb)) begin
                    decided_d = 1'b1;
                    dir_d     = a_msb;
                end
`ifdef EARLY_EXIT_EN
                finish = (cnt_q == CNT_W'(1)) || (!decided_q && (a_msb != b_msb));
`else
                finish = (cnt_q == CNT_W'(1));
`endif
                if (finish) begin
                    state_d = StDone;
                    res_d   = decided_d ? (dir_d ? RES_GT : RES_LT) : RES_EQ;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            decided_q <= 1'b0;
            dir_q     <= 1'b0;
            res_q     <= RES_NONE;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            decided_q <= decided_d;
            dir_q     <= dir_d;
            res_q     <= res_d;
        end
    end

    assign busy_o               = (state_q == StCmp);
    assign done_o               = (state_q == StDone);
    assign {gt_o, eq_o, lt_o}   = res_q;

endmodule
